// File: rtl/score_ram_pkg.sv
// Shared types and defaults for the score RAM.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package score_ram_pkg;

    // Default geometry: 64 player slots of 16-bit scores.
    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 16;

    // Request-to-result latency of a read, in clock cycles.
    localparam int RD_LAT = 2;

    // Clear-sweep controller states.
    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

endpackage

// File: rtl/score_ram_array.sv
// Plain synchronous single-port storage array with a registered read (read stage 1).
// Latency: write visible next cycle; read data registered one cycle after the request.
// Backpressure: none; accepts one write or one read per cycle.
//
// Ports:
//   clk   - clock
//   we    - write enable, writes wdata to addr
//   re    - read enable, captures mem[addr] into rdata
//   addr  - entry index
//   wdata - write data
//   rdata - registered read data (holds when re=0)
module score_ram_array
    import score_ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on the array: contents are zeroed by the clear sweep instead.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/score_ram.sv
// Score storage answering the scoreboard RAM interface; self-clears for a new game.
// Latency: read result 2 cycles after request (1/cycle throughput); writes visible next cycle.
// Backpressure: ready=0 during the clear sweep; requests seen then are dropped, not stalled.
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - single-cycle pulse restarting the clear sweep
//   wren      - 1 = write data to address, 0 = read address
//   address   - slot index; only the low ADDR_W bits are used
//   data      - write data
//   ram_data  - read data (holds when ram_valid=0)
//   ram_valid - ram_data carries a read result this cycle
//   ready     - requests are accepted
//
// Build option: define SCORE_RAM_CLEAR_EN to include the clear-sweep FSM and clr.
// Without it, clr is ignored, ready rises one edge after reset and contents
// are unspecified until written.
module score_ram
    import score_ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wren,
    input  logic [15:0]       address,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_valid,
    output logic              ready
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic              arr_we;
    logic              arr_re;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;

    logic              sweep;
    logic [ADDR_W-1:0] sweep_addr;

    // Upper address bits are aliased away by design.
    logic [15-ADDR_W:0] unused_addr_hi;
    assign unused_addr_hi = address[15:ADDR_W];

`ifdef SCORE_RAM_CLEAR_EN
    state_t           state;
    logic [CNT_W-1:0] cnt;

    // One extra counter bit so cnt never wraps back to 0 after the last entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (clr) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(DEPTH - 1)) begin
                            state <= S_READY;
                            ready <= 1'b1;
                        end
                    end
                end
                S_READY: begin
                    if (clr) begin
                        state <= S_CLEAR;
                        cnt   <= '0;
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state <= S_CLEAR;
                    cnt   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    assign sweep      = (state == S_CLEAR);
    assign sweep_addr = cnt[ADDR_W-1:0];
`else
    logic unused_clr;
    assign unused_clr = clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready <= 1'b0;
        end else begin
            ready <= 1'b1;
        end
    end

    assign sweep      = 1'b0;
    assign sweep_addr = '0;
`endif

    // The sweep owns the single port while it runs; otherwise the external
    // request goes through only when ready.
    always_comb begin
        arr_we    = 1'b0;
        arr_re    = 1'b0;
        arr_addr  = address[ADDR_W-1:0];
        arr_wdata = data;
        if (sweep) begin
            arr_we    = 1'b1;
            arr_addr  = sweep_addr;
            arr_wdata = '0;
        end else if (ready) begin
            arr_we = wren;
            arr_re = !wren;
        end
    end

    score_ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    // Valid bits travel alongside the data; bit 0 marks a valid stage-1 capture.
    logic [RD_LAT-1:0] vld_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            ram_data <= '0;
        end else begin
            vld_pipe <= {vld_pipe[RD_LAT-2:0], arr_re};
            if (vld_pipe[0]) begin
                ram_data <= arr_rdata;
            end
        end
    end

    assign ram_valid = vld_pipe[RD_LAT-1];

endmodule

// File: tb/tb_score_ram.sv
// Directed self-checking bench for score_ram: reset, read/write table, sweep and reset corners.
// Latency: checks the 2-cycle read latency and 1-cycle write visibility.
// Backpressure: checks ready timing around reset and clr.
module tb_score_ram;
    import score_ram_pkg::*;

    localparam int AW = 6;
    localparam int DW = 16;
`ifdef SCORE_RAM_CLEAR_EN
    localparam int EXP_SWEEP = 64;
`else
    localparam int EXP_SWEEP = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          wren;
    logic [15:0]   address;
    logic [DW-1:0] data;
    logic [DW-1:0] ram_data;
    logic          ram_valid;
    logic          ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wren;
        logic [15:0] addr;
        logic [15:0] data;
        logic        exp_vld;
        logic [15:0] exp_dat;
    } vec_t;

    vec_t vecs[18];

    score_ram #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .wren      (wren),
        .address   (address),
        .data      (data),
        .ram_data  (ram_data),
        .ram_valid (ram_valid),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts rising edges until ready goes high (bounded), then compares.
    task automatic count_sweep(input string name, input int exp_n);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check(name, n, exp_n);
    endtask

    initial begin
        // Outputs listed are those seen after the edge that takes this row's request.
        vecs[0]  = '{1'b1, 16'h0005, 16'h0042, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 16'h0005, 16'h0000, 1'b0, 16'h0000};
        vecs[2]  = '{1'b1, 16'h0045, 16'h1234, 1'b1, 16'h0042};
        vecs[3]  = '{1'b0, 16'h0005, 16'h0000, 1'b0, 16'h0042};
        vecs[4]  = '{1'b1, 16'h0001, 16'h0011, 1'b1, 16'h1234};
        vecs[5]  = '{1'b1, 16'h0002, 16'h0022, 1'b0, 16'h1234};
        vecs[6]  = '{1'b1, 16'h0003, 16'h0033, 1'b0, 16'h1234};
        vecs[7]  = '{1'b0, 16'h0001, 16'h0000, 1'b0, 16'h1234};
        vecs[8]  = '{1'b0, 16'h0002, 16'h0000, 1'b1, 16'h0011};
        vecs[9]  = '{1'b0, 16'h0003, 16'h0000, 1'b1, 16'h0022};
        vecs[10] = '{1'b1, 16'h003F, 16'hBEEF, 1'b1, 16'h0033};
        vecs[11] = '{1'b0, 16'h003F, 16'h0000, 1'b0, 16'h0033};
        vecs[12] = '{1'b1, 16'h0000, 16'hAAAA, 1'b1, 16'hBEEF};
        vecs[13] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'hBEEF};
        vecs[14] = '{1'b1, 16'h0000, 16'h5555, 1'b1, 16'hAAAA};
        vecs[15] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'hAAAA};
        vecs[16] = '{1'b1, 16'h0009, 16'h0000, 1'b1, 16'h5555};
        vecs[17] = '{1'b1, 16'h0009, 16'h0000, 1'b0, 16'h5555};

        rst     = 1'b1;
        clr     = 1'b0;
        wren    = 1'b1;
        address = 16'h0000;
        data    = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ram_data", ram_data, 0);
        check("rst_ram_valid", ram_valid, 0);
        check("rst_ready", ready, 0);
        rst = 1'b0;
        count_sweep("sweep_after_rst", EXP_SWEEP);

`ifdef SCORE_RAM_CLEAR_EN
        // Every entry reads back zero after the sweep.
        for (int i = 0; i < 64; i++) begin
            wren    = 1'b0;
            address = 16'(i);
            tick();
            if (i > 0) begin
                check($sformatf("zero_vld_%0d", i - 1), ram_valid, 1);
                check($sformatf("zero_dat_%0d", i - 1), ram_data, 0);
            end
        end
        wren    = 1'b1;
        address = 16'h0009;
        data    = 16'h0000;
        tick();
        check("zero_vld_63", ram_valid, 1);
        check("zero_dat_63", ram_data, 0);
`endif

        for (int i = 0; i < 18; i++) begin
            wren    = vecs[i].wren;
            address = vecs[i].addr;
            data    = vecs[i].data;
            tick();
            check($sformatf("vec%0d_vld", i), ram_valid, vecs[i].exp_vld);
            check($sformatf("vec%0d_dat", i), ram_data, vecs[i].exp_dat);
        end

        // Reset with reads in flight clears the outputs without waiting for an edge.
        wren    = 1'b0;
        address = 16'h0001;
        tick();
        address = 16'h0002;
        tick();
        check("inflight_vld", ram_valid, 1);
        check("inflight_dat", ram_data, 16'h0011);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_vld", ram_valid, 0);
        check("async_rst_dat", ram_data, 0);
        check("async_rst_ready", ready, 0);
        wren    = 1'b1;
        address = 16'h000A;
        data    = 16'h0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        count_sweep("sweep_after_rst2", EXP_SWEEP);

`ifdef SCORE_RAM_CLEAR_EN
        // Sweep zeroed entry 5 that previously held 0x1234.
        wren    = 1'b0;
        address = 16'h0005;
        tick();
        wren    = 1'b1;
        address = 16'h000A;
        tick();
        check("rezero_vld", ram_valid, 1);
        check("rezero_dat", ram_data, 0);

        // clr in ready: write that cycle is accepted, then the sweep wipes it.
        clr     = 1'b1;
        address = 16'h0008;
        data    = 16'h0808;
        tick();
        clr = 1'b0;
        check("clr_ready_drop", ready, 0);
        address = 16'h0004;
        data    = 16'h4444;
        repeat (30) tick();
        check("clr_mid_sweep_ready", ready, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        count_sweep("clr_restart_sweep", 64);
        wren    = 1'b0;
        address = 16'h0004;
        tick();
        address = 16'h0008;
        tick();
        check("dropped_wr_vld", ram_valid, 1);
        check("dropped_wr_dat", ram_data, 0);
        wren    = 1'b1;
        address = 16'h000A;
        data    = 16'h0000;
        tick();
        check("swept_wr_vld", ram_valid, 1);
        check("swept_wr_dat", ram_data, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/score_ram.md
# score_ram

Single-port score storage that answers the scoreboard's RAM interface (`wren`, `address`, `data` in; `ram_data` out) with a fixed two-cycle read latency. It is the memory end of that interface: it holds one 16-bit score per player slot, indexed by the low bits of the address the scoreboard drives. It clears itself after reset or on request so a new game starts from zero scores.

## Interface
Parameters:
- `ADDR_W`, default 6: implemented address bits; depth is 2^ADDR_W entries.
- `DATA_W`, default 16: entry width; must match the scoreboard `data`/`ram_data` width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `clr`  in  1  single-cycle pulse that restarts the clear sweep (new game).
- `wren`  in  1  1 = write `data` to `address` this cycle; 0 = read `address`.
- `address`  in  16  slot index; bits [15:ADDR_W] are ignored.
- `data`  in  DATA_W  write data.
- `ram_data`  out  DATA_W  read data, two cycles after the read request.
- `ram_valid`  out  1  `ram_data` carries a read result this cycle.
- `ready`  out  1  requests are accepted; 0 while the clear sweep runs.

## Operation
- FSM states: `S_CLEAR` and `S_READY`.
- `rst` enters `S_CLEAR` with the sweep counter at 0.
- `S_CLEAR`:
  - Writes 0 to entry `cnt` each cycle and increments `cnt`.
  - After writing entry 2^ADDR_W−1, moves to `S_READY`.
  - The counter is ADDR_W+1 bits so it never wraps.
- `S_READY`: on `clr`, enters `S_CLEAR` with `cnt`=0.
- `clr` during `S_CLEAR` restarts the sweep at entry 0.
- While `ready`=0, external writes are dropped. Reads are not issued, so no `ram_valid` is produced.
- Writes when `ready`=1: `mem[address[ADDR_W-1:0]] <= data` at the rising edge.
- Reads when `ready`=1 and `wren`=0:
  - Stage 1 captures `mem[addr]`.
  - Stage 2 registers it to `ram_data`.
  - A valid bit travels alongside and drives `ram_valid`.
- `ram_data` holds its last value when `ram_valid`=0.
- A write request produces no read result.
- Same-address ordering: a read issued in the cycle after a write returns the new value.
- Reset mid-operation:
  - In-flight reads are discarded; `ram_valid` drops at once.
  - Memory contents are not reset asynchronously; the sweep zeroes them.

## Timing
- Reset values: `ram_data`=0, `ram_valid`=0, `ready`=0, state `S_CLEAR`, `cnt`=0.
- Read latency is 2: a request in cycle k gives `ram_data`/`ram_valid` in cycle k+2. Throughput is one read per cycle.
- Write latency is 1: a write in cycle k is visible to reads issued in cycle k+1 or later.
- Sweep length is exactly 2^ADDR_W cycles.
  - `ready` rises in the cycle after the last clear write.
  - Example: ADDR_W=6 gives 64 cycles of `ready`=0 after `rst` deasserts.
- `clr` sampled high forces `ready`=0 from the next cycle.
- Reads issued before `clr` still complete their pipeline.
- `rst` and `clr` together: `rst` wins.

## Configuration
- Macro `SCORE_RAM_CLEAR_EN`.
- Defined: the clear sweep and `clr` behave as described above.
- Undefined:
  - The FSM is removed and `clr` is ignored.
  - `ready` goes to 1 at the first rising edge after `rst` deasserts.
  - Memory contents are unspecified until written.

## Structure
- Package `score_ram_pkg` holds:
  - the state enum (`S_CLEAR`, `S_READY`);
  - default `ADDR_W`/`DATA_W` localparams;
  - the read latency constant `RD_LAT`=2.
- Sub-module `score_ram_array`: plain synchronous single-port array (write port plus registered read, stage 1).
- The top level holds the FSM, sweep counter, write mux (sweep vs. external) and the stage-2/valid pipeline.

## Test plan
- Reset then idle → `ready`=0 for exactly 64 cycles (ADDR_W=6), then 1. A read of every address returns 0 with `ram_valid` two cycles later.
- Write 0x0042 to addr 5, read addr 5 the next cycle → `ram_data`=0x0042, `ram_valid`=1 two cycles after the read.
- Write addr 0x0045 (aliases 5) with 0x1234, then read 5 → 0x1234; entry 0x0005 was overwritten.
- Back-to-back reads of addr 1, 2, 3 (holding 0x11, 0x22, 0x33) → `ram_data` 0x11, 0x22, 0x33 in consecutive cycles, `ram_valid` high for 3 cycles.
- `clr` pulse at sweep cycle 30 → sweep restarts; `ready` stays 0 a further 64 cycles. Writes attempted meanwhile are lost (read returns 0).
- Assert `rst` with a read in flight → `ram_valid` and `ram_data` go to 0 immediately, asynchronously. With `SCORE_RAM_CLEAR_EN` undefined, `ready`=1 one cycle after release.
